// File: rtl/tc_host_driver.sv
// Host-side driver for one tensor core: streams A and transposed-B rows into the core,
// starts compute, then captures the M*N result stream into a result write port.
module tc_host_driver #(
  parameter int M       = 16,
  parameter int K       = 16,
  parameter int N       = 16,
  parameter int DW_MUL  = 8,
  parameter int DW_ADD  = 32,
  parameter int DW_ROW  = DW_MUL * K,
  parameter int W_IDX   = 16,
  parameter int TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err_timeout,
  output logic              src_type,
  output logic [W_IDX-1:0]  src_row,
  input  logic              src_valid,
  output logic              src_ready,
  input  logic [DW_ROW-1:0] src_data,
  output logic              tc_enable,
  output logic [DW_ROW-1:0] tc_in_i,
  output logic              tc_in_type,
  output logic              tc_in_state,
  input  logic [1:0]        tc_out_state,
  input  logic [DW_ADD-1:0] tc_out_i,
  input  logic              tc_finish,
  output logic              res_valid,
  output logic [W_IDX-1:0]  res_idx,
  output logic [DW_ADD-1:0] res_data,
  output logic [2:0]        dbg_state_o
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_KICK   = 3'd1;
  localparam logic [2:0] S_LOAD_A = 3'd2;
  localparam logic [2:0] S_LOAD_B = 3'd3;
  localparam logic [2:0] S_GO     = 3'd4;
  localparam logic [2:0] S_RUN    = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  localparam int W_TMO = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [W_IDX-1:0] LAST_A   = W_IDX'(M - 1);
  localparam logic [W_IDX-1:0] LAST_B   = W_IDX'(N - 1);
  localparam logic [W_IDX-1:0] LAST_K   = W_IDX'(M * N - 1);
  localparam logic [W_TMO-1:0] TMO_LAST = W_TMO'(TIMEOUT - 1);

  logic [2:0]        state_q, state_d;
  logic [W_IDX-1:0]  row_q, row_d;
  logic [W_IDX-1:0]  k_q, k_d;
  logic [W_TMO-1:0]  tmo_q, tmo_d;
  logic              cap_q, cap_d;
  logic              err_q, err_d;
  logic              res_valid_q, res_valid_d;
  logic [W_IDX-1:0]  res_idx_q, res_idx_d;
  logic [DW_ADD-1:0] res_data_q, res_data_d;

  logic in_load;
  assign in_load = (state_q == S_LOAD_A) || (state_q == S_LOAD_B);

  // Row handshake: a row transfers in every cycle where src_valid && src_ready.
  // src_type/src_row are held until that transfer; src_ready only rises in the load states.
  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    k_d         = k_q;
    tmo_d       = tmo_q;
    cap_d       = 1'b0;
    err_d       = err_q;
    res_valid_d = 1'b0;
    res_idx_d   = res_idx_q;
    res_data_d  = res_data_q;
    case (state_q)
      S_IDLE: begin
        if (start && (tc_out_state == 2'b00)) state_d = S_KICK;
      end
      S_KICK: begin
        row_d   = '0;
        state_d = S_LOAD_A;
      end
      S_LOAD_A: begin
        if (src_valid) begin
          if (row_q == LAST_A) begin
            row_d   = '0;
            state_d = S_LOAD_B;
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end
      S_LOAD_B: begin
        if (src_valid) begin
          if (row_q == LAST_B) begin
            row_d   = '0;
            state_d = S_GO;
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end
      S_GO: begin
        tmo_d   = '0;
        k_d     = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        cap_d = tc_finish && (tc_out_state == 2'b11);
        tmo_d = tmo_q + 1'b1;
        // The core presents S[k] on out_i one cycle after the finish tap, hence cap_q.
        if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          cap_d   = 1'b0;
          state_d = S_DONE;
        end else if (cap_q) begin
          res_valid_d = 1'b1;
          res_idx_d   = k_q;
          res_data_d  = tc_out_i;
          k_d         = k_q + 1'b1;
          if (k_q == LAST_K) state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      row_q       <= '0;
      k_q         <= '0;
      tmo_q       <= '0;
      cap_q       <= 1'b0;
      err_q       <= 1'b0;
      res_valid_q <= 1'b0;
      res_idx_q   <= '0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      k_q         <= k_d;
      tmo_q       <= tmo_d;
      cap_q       <= cap_d;
      err_q       <= err_d;
      res_valid_q <= res_valid_d;
      res_idx_q   <= res_idx_d;
      res_data_q  <= res_data_d;
    end
  end

  always_comb begin
    busy        = (state_q == S_KICK) || in_load || (state_q == S_GO) || (state_q == S_RUN);
    done        = (state_q == S_DONE);
    src_type    = (state_q == S_LOAD_B);
    src_row     = in_load ? row_q : '0;
    src_ready   = in_load && src_valid;
    tc_enable   = (state_q == S_KICK) || (state_q == S_GO) || (state_q == S_RUN) ||
                  (in_load && src_valid);
    tc_in_i     = (in_load && src_valid) ? src_data : '0;
    tc_in_type  = (state_q == S_LOAD_B);
    tc_in_state = (state_q == S_KICK) || (state_q == S_GO);
  end

  assign err_timeout = err_q;
  assign res_valid   = res_valid_q;
  assign res_idx     = res_idx_q;
  assign res_data    = res_data_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_tc_host_driver.sv
// Bench for tc_host_driver with a small behavioural tensor core and a row source,
// M=K=N=4, TIMEOUT=50.
module tb_tc_host_driver;
  localparam int M = 4, K = 4, N = 4, DW_MUL = 8, DW_ADD = 32, W_IDX = 16, TIMEOUT = 50;
  localparam int DW_ROW = DW_MUL * K;
  localparam logic [2:0] ST_IDLE = 3'd0, ST_LOAD_B = 3'd3, ST_RUN = 3'd5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic busy, done, err_timeout, src_type, src_ready, tc_enable, tc_in_type, tc_in_state;
  logic [W_IDX-1:0] src_row, res_idx;
  logic src_valid;
  logic [DW_ROW-1:0] src_data, tc_in_i;
  logic [1:0] tc_out_state;
  logic [DW_ADD-1:0] tc_out_i, res_data;
  logic tc_finish, res_valid;
  logic [2:0] dbg_state_o;

  always #5 clk = ~clk;

  tc_host_driver #(.M(M), .K(K), .N(N), .DW_MUL(DW_MUL), .DW_ADD(DW_ADD), .DW_ROW(DW_ROW),
                   .W_IDX(W_IDX), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .err_timeout(err_timeout), .src_type(src_type), .src_row(src_row),
    .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
    .tc_enable(tc_enable), .tc_in_i(tc_in_i), .tc_in_type(tc_in_type),
    .tc_in_state(tc_in_state), .tc_out_state(tc_out_state), .tc_out_i(tc_out_i),
    .tc_finish(tc_finish), .res_valid(res_valid), .res_idx(res_idx),
    .res_data(res_data), .dbg_state_o(dbg_state_o)
  );

  // Row source: A = identity, B row j = {j+1 repeated}.
  logic [DW_ROW-1:0] a_tab [M];
  logic [DW_ROW-1:0] b_tab [N];
  int vmode = 0;
  bit hold_fin = 1'b0;
  assign src_data = src_type ? b_tab[src_row[1:0]] : a_tab[src_row[1:0]];

  initial begin
    src_valid = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      src_valid = (vmode != 0) ? ~src_valid : 1'b1;
    end
  end

  // Behavioural tensor core: 00 idle, 01 loading, 10 computing, 11 streaming S = A * Bt^T.
  logic [1:0] cst;
  int wa, wb, ccnt, oidx;
  logic [DW_ROW-1:0] a_rx [M];
  logic [DW_ROW-1:0] b_rx [N];
  logic [DW_ADD-1:0] cout;

  function automatic logic [DW_ADD-1:0] s_val(input int idx);
    logic [DW_ADD-1:0] acc;
    int m, n;
    m = idx / N;
    n = idx % N;
    acc = '0;
    for (int kk = 0; kk < K; kk++)
      acc = acc + DW_ADD'(a_rx[m][DW_MUL*kk +: DW_MUL]) * DW_ADD'(b_rx[n][DW_MUL*kk +: DW_MUL]);
    return acc;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      cst <= 2'b00; wa <= 0; wb <= 0; ccnt <= 0; oidx <= 0; cout <= '0;
    end else if (tc_enable) begin
      case (cst)
        2'b00: if (tc_in_state) cst <= 2'b01;
        2'b01: begin
          if (tc_in_state) begin
            cst <= 2'b10; ccnt <= 0;
          end else if (!tc_in_type) begin
            if (wa < M) a_rx[wa] <= tc_in_i;
            wa <= wa + 1;
          end else begin
            if (wb < N) b_rx[wb] <= tc_in_i;
            wb <= wb + 1;
          end
        end
        2'b10: begin
          ccnt <= ccnt + 1;
          if (ccnt == 3) begin cst <= 2'b11; oidx <= 0; end
        end
        default: if (tc_finish) begin cout <= s_val(oidx); oidx <= oidx + 1; end
      endcase
    end
  end

  assign tc_out_state = cst;
  assign tc_out_i     = cout;
  assign tc_finish    = (cst == 2'b11) && (oidx < M * N) && !hold_fin;

  // Checking state
  typedef struct { int idx; logic [DW_ADD-1:0] data; } res_t;
  typedef struct { int vmode; bit hold_fin; bit run_starts; int exp_res; bit exp_err; int exp_run; } job_t;
  res_t res_tab [M*N];
  job_t jobs [4];
  logic [W_IDX+DW_ADD-1:0] exp_q [$];
  logic [W_IDX+DW_ADD-1:0] got, want;
  int n_cmp = 0, n_fail = 0;
  int cyc = 0, wr_cnt, first_wr, last_wr, order_bad, stall_cnt, stall_bad;
  int run_cnt, done_cnt, busy_cnt, rdy_cnt, res_cnt;
  bit saw_b;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clear_mon();
    wr_cnt = 0; first_wr = -1; last_wr = -1; order_bad = 0; stall_cnt = 0; stall_bad = 0;
    run_cnt = 0; done_cnt = 0; busy_cnt = 0; rdy_cnt = 0; res_cnt = 0; saw_b = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (cst == 2'b01 && tc_enable && !tc_in_state) begin
      wr_cnt++;
      if (first_wr < 0) first_wr = cyc;
      last_wr = cyc;
      if (!tc_in_type && saw_b) order_bad++;
      if (tc_in_type) saw_b = 1'b1;
    end
    if (cst == 2'b01 && !tc_in_state && !src_valid) begin
      stall_cnt++;
      if (tc_enable || src_ready) stall_bad++;
    end
    if (dbg_state_o == ST_RUN) run_cnt++;
    if (done) done_cnt++;
    if (busy) busy_cnt++;
    if (src_ready) rdy_cnt++;
    if (res_valid) begin
      res_cnt++;
      got = {res_idx, res_data};
      if (exp_q.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL res_unexpected: got idx %0d data %0h required none", res_idx, res_data);
      end else begin
        want = exp_q.pop_front();
        chk("res_word", 64'(got), 64'(want));
      end
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1; start = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic run_job(input job_t j, input bit do_rst);
    int rs;
    bit seen;
    if (do_rst) apply_reset();
    vmode = j.vmode; hold_fin = j.hold_fin;
    clear_mon();
    if (j.exp_res > 0)
      for (int i = 0; i < M * N; i++) exp_q.push_back({W_IDX'(res_tab[i].idx), res_tab[i].data});
    start = 1'b1;
    tick();
    start = 1'b0;
    rs = 0;
    for (int c = 0; c < 400 && done_cnt == 0; c++) begin
      if (j.run_starts && dbg_state_o == ST_RUN && rs < 2 && run_cnt > 2) begin
        start = 1'b1; rs++;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    seen = (done_cnt != 0);
    repeat (4) tick();
    chk("done_reached", 64'(seen), 64'd1);
    chk("done_pulses", 64'(done_cnt), 64'd1);
    chk("res_count", 64'(res_cnt), 64'(j.exp_res));
    chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
    chk("err_timeout", 64'(err_timeout), 64'(j.exp_err));
    chk("row_writes", 64'(wr_cnt), 64'(M + N));
    chk("a_before_b", 64'(order_bad), 64'd0);
    chk("stall_enable", 64'(stall_bad), 64'd0);
    chk("busy_after", 64'(busy), 64'd0);
    if (j.vmode == 0) chk("load_burst", 64'(last_wr - first_wr), 64'(M + N - 1));
    else              chk("stalls_seen", 64'(stall_cnt != 0), 64'd1);
    if (j.exp_run >= 0) chk("run_cycles", 64'(run_cnt), 64'(j.exp_run));
    exp_q.delete();
  endtask

  initial begin
    bool_setup();
  end

  task automatic bool_setup();
    bit hit;
    for (int r = 0; r < M; r++) begin
      a_tab[r] = '0;
      a_tab[r][DW_MUL*r +: DW_MUL] = 8'd1;
    end
    for (int r = 0; r < N; r++)
      for (int kk = 0; kk < K; kk++) b_tab[r][DW_MUL*kk +: DW_MUL] = 8'(r + 1);
    // S[m][n] = B[n][m] = n+1
    for (int i = 0; i < M * N; i++) res_tab[i] = '{idx: i, data: DW_ADD'((i % N) + 1)};
    jobs[0] = '{vmode: 0, hold_fin: 0, run_starts: 0, exp_res: M*N, exp_err: 0, exp_run: -1};
    jobs[1] = '{vmode: 1, hold_fin: 0, run_starts: 0, exp_res: M*N, exp_err: 0, exp_run: -1};
    jobs[2] = '{vmode: 0, hold_fin: 0, run_starts: 1, exp_res: M*N, exp_err: 0, exp_run: -1};
    jobs[3] = '{vmode: 0, hold_fin: 1, run_starts: 0, exp_res: 0,   exp_err: 1, exp_run: TIMEOUT};

    clear_mon();
    apply_reset();
    chk("rst_state", 64'(dbg_state_o), 64'(ST_IDLE));
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err_timeout), 64'd0);
    chk("rst_enable", 64'(tc_enable), 64'd0);
    chk("rst_res", 64'({res_valid, res_idx, res_data}), 64'd0);

    for (int j = 0; j < 4; j++) run_job(jobs[j], 1'b1);

    // Core left in 11: start must be ignored.
    chk("core_busy_state", 64'(tc_out_state), 64'd3);
    clear_mon();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    chk("ign_busy", 64'(busy_cnt), 64'd0);
    chk("ign_src_ready", 64'(rdy_cnt), 64'd0);
    chk("ign_state", 64'(dbg_state_o), 64'(ST_IDLE));
    chk("err_sticky", 64'(err_timeout), 64'd1);

    // Reset in the middle of LOAD_B, then a fresh job.
    apply_reset();
    vmode = 1; hold_fin = 1'b0;
    clear_mon();
    start = 1'b1;
    tick();
    start = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 100 && !hit; c++) begin
      tick();
      hit = (dbg_state_o == ST_LOAD_B);
    end
    chk("reached_load_b", 64'(hit), 64'd1);
    reset = 1'b1;
    tick();
    chk("mid_rst_state", 64'(dbg_state_o), 64'(ST_IDLE));
    chk("mid_rst_ctrl", 64'({busy, done, err_timeout, src_ready, src_type, tc_enable, tc_in_type, tc_in_state}), 64'd0);
    chk("mid_rst_row", 64'(src_row), 64'd0);
    chk("mid_rst_res", 64'({res_valid, res_idx, res_data}), 64'd0);
    reset = 1'b0;
    tick();
    chk("mid_rst_no_done", 64'(done_cnt), 64'd0);
    run_job(jobs[0], 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  endtask

endmodule

// File: doc/tc_host_driver.md
Name: tc_host_driver

Overview:
- Host-side transmitter and receiver for the tensor core's load/compute/readout protocol.
- Fetches A rows and transposed-B rows from a row source and streams them into the core with the in_i/in_type/in_state handshake.
- Kicks off compute, then captures the M*N debug result stream from out_i into a result write port.
- Sits between the system-level matrix buffers and one tensor core instance; it owns the core's enable.

Parameters:
M, 16, rows of A / rows of S
K, 16, reduction length; elements per loaded row
N, 16, columns of B / columns of S (B is loaded as N rows of K)
DW_MUL, 8, element width of A/B
DW_ADD, 32, result element width
DW_ROW, DW_MUL*K, packed row width (derived)
W_IDX, 16, width of row and result index counters (must hold max(M,N,M*N))
TIMEOUT, 65535, max cycles spent in RUN before the error is flagged

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
start  in  1  pulse; begins a full load/compute/readout job
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse when the last result has been written
err_timeout  out  1  sticky; set when RUN exceeds TIMEOUT, cleared by reset
src_type  out  1  0: A row requested, 1: B row requested
src_row  out  W_IDX  requested row index
src_valid  in  1  src_data is valid for (src_type, src_row)
src_ready  out  1  row consumed this cycle
src_data  in  DW_ROW  packed row; element i at [DW_MUL*i +: DW_MUL]
tc_enable  out  1  drives core enable
tc_in_i  out  DW_ROW  drives core in_i
tc_in_type  out  1  drives core in_type
tc_in_state  out  1  drives core in_state
tc_out_state  in  2  core out_state (00 idle, 01 loading, 10 computing, 11 all_send)
tc_out_i  in  DW_ADD  core out_i
tc_finish  in  1  core psum unit out_flag==2'b11 tap
res_valid  out  1  result write strobe
res_idx  out  W_IDX  result index, row-major m*N+n
res_data  out  DW_ADD  result value

Behaviour:
- Reset: FSM to IDLE; all counters 0; err_timeout 0; all outputs 0.
- Core-side outputs (tc_*) and src_ready are combinational decodes of the FSM state, the counters, and src_valid.
- res_* outputs are registered.
- IDLE:
  - tc_enable=0.
  - start is accepted only when tc_out_state==00; otherwise it is ignored.
  - On acceptance: busy=1, go to KICK.
- KICK (1 cycle): tc_enable=1, tc_in_state=1. Go to LOAD_A with row=0.
- LOAD_A:
  - Outputs: src_type=0, src_row=row, tc_in_type=0, tc_in_state=0.
  - If src_valid: tc_enable=1, tc_in_i=src_data, src_ready=1, row++.
  - Else: tc_enable=0, so the core writes nothing.
  - src_type and src_row hold stable until the row is accepted.
  - When row M-1 is accepted: row=0, go to LOAD_B.
- LOAD_B: same as LOAD_A with type=1, over N rows. After row N-1 is accepted, go to GO.
- GO (1 cycle): tc_enable=1, tc_in_state=1 (core moves 01->10). Clear the timeout counter. Go to RUN.
- RUN:
  - tc_enable=1 and tc_in_state=0 continuously.
  - cap = tc_finish && tc_out_state==11. Register cap as cap_d.
  - The core updates out_i on the edge after a cap cycle, so tc_out_i holds S[k] in every cycle where cap_d=1.
  - In each cap_d cycle: register res_valid=1, res_idx=k, res_data=tc_out_i, then k++.
  - After the capture with k==M*N-1, go to DONE.
  - Timeout counter increments each RUN cycle. On reaching TIMEOUT: set err_timeout, go to DONE without further captures.
- DONE (1 cycle): done=1, tc_enable=0, busy=0, back to IDLE.
  - The core remains in 11 after a job; the next start is ignored until reset returns the core to 00.
- start while busy: ignored. src_valid outside LOAD_A/LOAD_B: ignored, src_ready=0.
- Reset mid-operation: immediate return to IDLE; no done pulse; no further res_valid.

Test Plan:
- M=K=N=4, A=identity, B row j = {j+1 repeated} (with src_valid always 1) -> exactly 4 A writes then 4 B writes on consecutive cycles; 16 res_valid in order; res_data at idx m*4+n = B[n][m]; one done pulse.
- Same job with src_valid toggling 1/0 -> tc_enable low on every stall cycle; result set identical to the all-ones run.
- start asserted with tc_out_state==11 (core not reset) -> no KICK, busy stays 0, no src traffic.
- reset asserted mid-LOAD_B -> next cycle all outputs 0 and state IDLE; a fresh start after reset completes normally.
- tc_finish held 0 with TIMEOUT=50 -> err_timeout rises after 50 RUN cycles; done pulses once; zero res_valid.
- start pulses during RUN -> ignored; exactly M*N results and one done.
